// File: rtl/writeback_queue.sv
// writeback_queue: buffers up to DEPTH writeback requests and drains them in
// order, one per cycle, to the int/float register file and the PC register.
// Ports:
//   clk, rstn                  clock, asynchronous active-low reset
//   enable / ready             request handshake (accepted when both high)
//   wselector, pc, data, rd    request payload ([2]=PC, [1]=reg, [0]=float)
//   flush                      discard queued, not-yet-issued requests
//   wack                       register file accepts the presented write
//   pcenable, next_pc          PC write strobe and value
//   wenable, fmode, wreg, wdata register write strobe, file select, address, data
//   done                       one-cycle pulse per retired request
//   count                      requests held in the FIFO (output stage excluded)
module writeback_queue #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned RADDR = 5,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     enable,
  output logic                     ready,
  input  logic [2:0]               wselector,
  input  logic [XLEN-1:0]          pc,
  input  logic [XLEN-1:0]          data,
  input  logic [RADDR-1:0]         rd,
  input  logic                     flush,
  input  logic                     wack,
  output logic                     pcenable,
  output logic [XLEN-1:0]          next_pc,
  output logic                     wenable,
  output logic                     fmode,
  output logic [RADDR-1:0]         wreg,
  output logic [XLEN-1:0]          wdata,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [2:0]       wsel;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  data;
    logic [RADDR-1:0] rd;
  } entry_t;

  // Register-write part; an integer write to x0 is dropped.
  function automatic logic reg_part(input entry_t e);
    return e.wsel[1] && !(!e.wsel[0] && (e.rd == '0));
  endfunction

  function automatic logic is_write(input entry_t e);
    return e.wsel[2] || reg_part(e);
  endfunction

  entry_t         mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;

  entry_t         in_e;
  entry_t         head_e;
  entry_t         load_e;
  logic           accept;
  logic           stage_valid;
  logic           stage_retire;
  logic           stage_free;
  logic           push;
  logic           pop;
  logic           load;
  logic           null_retire;
  logic [CW-1:0]  count_nxt;

  assign in_e = '{wsel: wselector, pc: pc, data: data, rd: rd};

  // Queue control: stage loading, null retirement, push/pop decisions.
  always_comb begin
    head_e       = mem[rd_ptr];
    accept       = enable && ready;
    stage_valid  = pcenable || wenable;
    stage_retire = stage_valid && (!wenable || wack);
    stage_free   = !stage_valid || stage_retire;
    push         = 1'b0;
    pop          = 1'b0;
    load         = 1'b0;
    load_e       = head_e;
    null_retire  = 1'b0;
    if (!flush) begin
      if (count != '0) begin
        push = accept;
        if (is_write(head_e)) begin
          if (stage_free) begin
            pop  = 1'b1;
            load = 1'b1;
          end
        end else if (!stage_valid) begin
          // A null may only retire when nothing older is still issuing.
          pop         = 1'b1;
          null_retire = 1'b1;
        end
      end else if (accept) begin
        // Empty FIFO: the new request bypasses straight to the stage.
        if (is_write(in_e)) begin
          if (stage_free) begin
            load   = 1'b1;
            load_e = in_e;
          end else begin
            push = 1'b1;
          end
        end else if (!stage_valid) begin
          null_retire = 1'b1;
        end else begin
          push = 1'b1;
        end
      end
    end
    if (flush) begin
      count_nxt = '0;
    end else begin
      count_nxt = count + CW'(push) - CW'(pop);
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_e;
    end
  end

  // Pointers, counters, handshake and output stage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      ready    <= 1'b0;
      done     <= 1'b1;
      pcenable <= 1'b0;
      wenable  <= 1'b0;
      fmode    <= 1'b0;
      wreg     <= '0;
      wdata    <= '0;
      next_pc  <= '0;
    end else begin
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
      end
      count <= count_nxt;
      ready <= (count_nxt < CW'(DEPTH));
      done  <= stage_retire || null_retire;
      if (load) begin
        pcenable <= load_e.wsel[2];
        wenable  <= reg_part(load_e);
        fmode    <= load_e.wsel[0];
        wreg     <= load_e.rd;
        wdata    <= load_e.data;
        next_pc  <= load_e.pc;
      end else if (stage_retire) begin
        pcenable <= 1'b0;
        wenable  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/writeback_queue.md
Name: writeback_queue

Overview:
Parametrised successor to the single-shot writeback stage. It buffers up to DEPTH writeback requests in a FIFO and drains them in order, one per cycle, to the integer/float register file and the PC register. Register-file back-pressure is handled with a write acknowledge. It produces one done pulse per retired request, so the execute stage can run ahead of writeback. It sits between execute/memory and the register file / PC register.

Parameters:
XLEN, 32, data/PC width
RADDR, 5, register address width
DEPTH, 4, FIFO entries; power of 2, >= 2

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
enable  in  1  request valid; accepted when enable && ready
ready  out  1  queue can accept this cycle
wselector  in  3  [2]=PC write, [1]=reg write, [0]=float regfile select
pc  in  XLEN  next PC for a PC write
data  in  XLEN  register write data
rd  in  RADDR  destination register
flush  in  1  synchronous discard of queued, not-yet-issued entries
wack  in  1  register file accepts the presented write
pcenable  out  1  PC write strobe
next_pc  out  XLEN  PC write value
wenable  out  1  register write strobe
fmode  out  1  1 = float register file
wreg  out  RADDR  write address
wdata  out  XLEN  write data
done  out  1  one-cycle pulse per retired entry
count  out  $clog2(DEPTH)+1  entries held in the queue; the output stage is not counted

Behaviour:
- Reset, asynchronous on rstn low. Queue is emptied and count=0.
- Reset values: pcenable=0, wenable=0, fmode=0, wreg=0, wdata=0, next_pc=0, ready=0.
- done=1 while in reset. At the first clock edge after release, done goes to 0 (start token, as before). ready goes to 1 at that same edge.
- ready = (count < DEPTH), registered. When full there is no same-cycle accept, even if a pop happens in that cycle.
- An entry stores {wselector, pc, data, rd}.
- An entry is a write entry when wselector[2]=1, or when wselector[1]=1 and not (wselector[0]=0 and rd=0).
  - An integer write to x0 is suppressed: its reg-write part is dropped.
  - An entry left with no write is a null entry.
- Output stage: one register holding the issuing entry.
- Output stage, loading:
  - It loads the FIFO head at any edge where the stage is free, or is retiring its entry at that edge.
  - When the FIFO is empty, an accepted entry bypasses the FIFO straight into the stage.
- Output stage, presenting an entry:
  - pcenable = wselector[2]; next_pc = pc.
  - wenable = reg-write part; fmode = wselector[0]; wreg = rd; wdata = data.
  - The strobes are held until retire.
- Retire rules:
  - An entry with wenable=1 retires at the first edge where wack=1.
  - A PC-only entry retires at the next edge; wack is ignored.
  - pcenable drops at the same edge as wenable.
- Latency, empty queue, entry accepted at edge E0:
  - Write entry: strobes high in the cycle after E0. Retire at E1 if wack=1. done high for the cycle after E1.
  - Null entry: it never occupies the stage; done high for the cycle after E0.
- Null entries behind the head pop without entering the output stage. They still retire strictly in order: at most one done pulse per cycle, one entry retired per cycle.
- Throughput with wack held at 1: one entry per cycle; done pulses every cycle.
- Simultaneous accept and pop: count is unchanged.
- FIFO pointers wrap modulo DEPTH.
- flush, at its edge:
  - Discards every FIFO entry; count=0.
  - An entry arriving with enable at the same edge is also discarded.
  - The entry already in the output stage still completes and pulses done.
  - Discarded entries produce no done.
- Reset mid-operation: all strobes drop immediately (asynchronously); no done for in-flight entries.

Test Plan:
- Reset release, no traffic -> done=1 during reset, done=0 after the first edge; ready=1, count=0, all strobes 0.
- Single write entry (wselector=3'b010, rd=5, data=32'hDEAD_BEEF), wack=1 -> wenable=1, wreg=5, wdata=32'hDEAD_BEEF, fmode=0 in the next cycle; one done pulse the cycle after.
- Entry wselector=3'b110, pc=32'h100, rd=3, data=7, wack held 0 for 3 cycles -> wenable and pcenable both held 4 cycles; next_pc=32'h100; done 1 cycle after wack rises.
- Null entry (3'b000) and x0 integer write (3'b010, rd=0) -> no strobes at all; done in the cycle after acceptance for each.
- DEPTH+2 back-to-back entries with wack=0 -> ready drops once count=4; with wack=1 after that, in-order writes one per cycle and exactly 6 done pulses.
- Queue holding 3 entries plus 1 issuing, flush=1 -> count=0; only the issuing entry writes and pulses done. Then assert rstn=0 mid-write -> wenable=0 immediately.
